bus_arbiter: RTL and testbench

- Shared-memory bus arbiter for the next-generation core, replacing the separate zero-wait instruction ROM and data RAM ports.
- Arbitrates the IF-stage fetch port and the MEM-stage data port onto one variable-latency memory port (req/ack handshake).
- Returns per-port ready pulses and a stall request to the pipeline controller.
- Adds a watchdog timeout with bus-error reporting and fetch discard on flush.

---
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Shares one variable-latency memory port between the fetch and data ports.
// Data wins ties, a watchdog aborts hung transactions, and flush discards fetches.
module bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req_i,
   input  logic [ADDR_W-1:0]   inst_addr_i,
   output logic [DATA_W-1:0]   inst_data_o,
   output logic                inst_ready_o,
   input  logic                data_req_i,
   input  logic                data_we_i,
   input  logic [DATA_W/8-1:0] data_sel_i,
   input  logic [ADDR_W-1:0]   data_addr_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic [DATA_W-1:0]   data_rdata_o,
   output logic                data_ready_o,
   input  logic                flush_i,
   output logic                stallreq_o,
   output logic                bus_err_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_sel_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_ack_i
);

   // state | meaning
   // IDLE  | no transaction; data request has priority over fetch
   // INST  | fetch on the bus, waiting for ack or watchdog expiry
   // DATA  | load/store on the bus, waiting for ack or watchdog expiry
   // RESP  | one-cycle completion: ready (and bus_err on abort) pulse
   typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_next;
   logic             wd_expire;
   logic             discard;
   logic             inst_ready_q;

   assign wd_next   = wd_cnt + CNT_W'(1);
   assign wd_expire = (TIMEOUT != 0) && (wd_next == CNT_W'(TIMEOUT));

   // a flush arriving in the RESP cycle itself must still kill the fetch pulse
   assign inst_ready_o = inst_ready_q & ~flush_i;
   assign stallreq_o   = (inst_req_i & ~inst_ready_o & ~flush_i) |
                         (data_req_i & ~data_ready_o);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wd_cnt       <= '0;
         discard      <= 1'b0;
         inst_ready_q <= 1'b0;
         data_ready_o <= 1'b0;
         bus_err_o    <= 1'b0;
         inst_data_o  <= '0;
         data_rdata_o <= '0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_sel_o    <= '0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
      end else begin
         inst_ready_q <= 1'b0;
         data_ready_o <= 1'b0;
         bus_err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (data_req_i) begin
                  state       <= DATA;
                  wd_cnt      <= '0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= data_we_i;
                  mem_sel_o   <= data_sel_i;
                  mem_addr_o  <= data_addr_i;
                  mem_wdata_o <= data_wdata_i;
               end else if (inst_req_i && !flush_i) begin
                  state       <= INST;
                  wd_cnt      <= '0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_sel_o   <= '1;
                  mem_addr_o  <= inst_addr_i;
                  mem_wdata_o <= '0;
               end
            end
            INST: begin
               if (flush_i)
                  discard <= 1'b1;
               if (mem_ack_i || wd_expire) begin
                  state        <= RESP;
                  mem_req_o    <= 1'b0;
                  inst_data_o  <= mem_ack_i ? mem_rdata_i : '0;
                  inst_ready_q <= !(discard || flush_i);
                  bus_err_o    <= !mem_ack_i;
               end else begin
                  wd_cnt <= wd_next;
               end
            end
            DATA: begin
               if (mem_ack_i || wd_expire) begin
                  state        <= RESP;
                  mem_req_o    <= 1'b0;
                  data_rdata_o <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                  data_ready_o <= 1'b1;
                  bus_err_o    <= !mem_ack_i;
               end else begin
                  wd_cnt <= wd_next;
               end
            end
            RESP: begin
               state   <= IDLE;
               discard <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a short watchdog (TIMEOUT=4).
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req_i;
   logic [31:0] inst_addr_i;
   logic [31:0] inst_data_o;
   logic        inst_ready_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_sel_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic        data_ready_o;
   logic        flush_i;
   logic        stallreq_o;
   logic        bus_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
      .inst_data_o(inst_data_o), .inst_ready_o(inst_ready_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
      .flush_i(flush_i), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // cycle boundary: inputs change and outputs are sampled 2ns after the edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b0;
      inst_req_i = 1'b0; inst_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_sel_i = '0;
      data_addr_i = '0; data_wdata_i = '0;
      flush_i = 1'b0; mem_rdata_i = '0; mem_ack_i = 1'b0;

      // reset state
      step(); step();
      chk1("rst_mem_req", mem_req_o, 1'b0);
      chk1("rst_inst_ready", inst_ready_o, 1'b0);
      chk1("rst_data_ready", data_ready_o, 1'b0);
      chk1("rst_bus_err", bus_err_o, 1'b0);
      chk32("rst_mem_addr", mem_addr_o, 32'h0);
      #3 rst = 1'b1;

      // fetch with ack latency 3
      step();
      inst_req_i = 1'b1; inst_addr_i = 32'h100;
      #1 chk1("f_c0_stall", stallreq_o, 1'b1);
      chk1("f_c0_mem_req", mem_req_o, 1'b0);
      step();
      chk1("f_c1_mem_req", mem_req_o, 1'b1);
      chk32("f_c1_addr", mem_addr_o, 32'h100);
      chk1("f_c1_we", mem_we_o, 1'b0);
      chk1("f_c1_stall", stallreq_o, 1'b1);
      step();
      chk1("f_c2_mem_req", mem_req_o, 1'b1);
      chk1("f_c2_stall", stallreq_o, 1'b1);
      step();
      chk1("f_c3_mem_req", mem_req_o, 1'b1);
      chk1("f_c3_ready", inst_ready_o, 1'b0);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h3C011234;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("f_c4_mem_req", mem_req_o, 1'b0);
      chk1("f_c4_ready", inst_ready_o, 1'b1);
      chk32("f_c4_data", inst_data_o, 32'h3C011234);
      chk1("f_c4_stall", stallreq_o, 1'b0);
      chk1("f_c4_err", bus_err_o, 1'b0);
      inst_req_i = 1'b0;
      step();
      chk1("f_c5_ready", inst_ready_o, 1'b0);
      chk32("f_c5_data_hold", inst_data_o, 32'h3C011234);

      // simultaneous data load and fetch
      data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h2000;
      inst_req_i = 1'b1; inst_addr_i = 32'h104;
      step();
      chk1("s_c1_mem_req", mem_req_o, 1'b1);
      chk32("s_c1_addr", mem_addr_o, 32'h2000);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A50001;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("s_c2_data_ready", data_ready_o, 1'b1);
      chk32("s_c2_rdata", data_rdata_o, 32'hA5A50001);
      chk1("s_c2_inst_ready", inst_ready_o, 1'b0);
      chk1("s_c2_stall", stallreq_o, 1'b1);
      data_req_i = 1'b0;
      step();
      chk1("s_c3_mem_req", mem_req_o, 1'b0);
      chk1("s_c3_data_ready", data_ready_o, 1'b0);
      step();
      chk1("s_c4_mem_req", mem_req_o, 1'b1);
      chk32("s_c4_addr", mem_addr_o, 32'h104);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h00001111;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("s_c5_inst_ready", inst_ready_o, 1'b1);
      chk32("s_c5_inst_data", inst_data_o, 32'h00001111);
      chk1("s_c5_data_ready", data_ready_o, 1'b0);
      inst_req_i = 1'b0;
      step();

      // watchdog expiry on a load
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h300;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk1($sformatf("t_c%0d_mem_req", i), mem_req_o, 1'b1);
         chk1($sformatf("t_c%0d_err", i), bus_err_o, 1'b0);
      end
      step();
      chk1("t_c5_mem_req", mem_req_o, 1'b0);
      chk1("t_c5_data_ready", data_ready_o, 1'b1);
      chk1("t_c5_err", bus_err_o, 1'b1);
      chk32("t_c5_rdata", data_rdata_o, 32'h0);
      data_req_i = 1'b0;
      step();
      chk1("t_c6_err", bus_err_o, 1'b0);
      chk1("t_c6_data_ready", data_ready_o, 1'b0);

      // ack exactly at expiry wins
      data_req_i = 1'b1; data_addr_i = 32'h304;
      step(); step(); step(); step();
      chk1("e_c4_mem_req", mem_req_o, 1'b1);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("e_c5_data_ready", data_ready_o, 1'b1);
      chk1("e_c5_err", bus_err_o, 1'b0);
      chk32("e_c5_rdata", data_rdata_o, 32'h12345678);
      data_req_i = 1'b0;
      step();

      // store
      data_req_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'b0011;
      data_wdata_i = 32'hDEADBEEF; data_addr_i = 32'h40;
      step();
      chk1("w_c1_we", mem_we_o, 1'b1);
      chk32("w_c1_sel", {28'h0, mem_sel_o}, 32'h3);
      chk32("w_c1_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk32("w_c1_addr", mem_addr_o, 32'h40);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("w_c2_data_ready", data_ready_o, 1'b1);
      chk32("w_c2_rdata", data_rdata_o, 32'h0);
      data_req_i = 1'b0; data_we_i = 1'b0;
      step();

      // flush during a fetch
      inst_req_i = 1'b1; inst_addr_i = 32'h180;
      step();
      chk1("fl_c1_mem_req", mem_req_o, 1'b1);
      step();
      flush_i = 1'b1;
      #1 chk1("fl_c2_stall", stallreq_o, 1'b0);
      step();
      flush_i = 1'b0;
      #1 chk1("fl_c3_mem_req", mem_req_o, 1'b1);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h00000077;
      step();
      mem_ack_i = 1'b0;
      inst_addr_i = 32'h200;
      #1 chk1("fl_c4_ready", inst_ready_o, 1'b0);
      chk1("fl_c4_mem_req", mem_req_o, 1'b0);
      chk1("fl_c4_err", bus_err_o, 1'b0);
      step();
      chk1("fl_c5_mem_req", mem_req_o, 1'b0);
      chk1("fl_c5_ready", inst_ready_o, 1'b0);
      step();
      chk1("fl_c6_mem_req", mem_req_o, 1'b1);
      chk32("fl_c6_addr", mem_addr_o, 32'h200);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h00200200;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("fl_c7_ready", inst_ready_o, 1'b1);
      chk32("fl_c7_data", inst_data_o, 32'h00200200);
      inst_req_i = 1'b0;
      step();

      // async reset in the middle of a data transaction
      data_req_i = 1'b1; data_addr_i = 32'h400;
      step();
      chk1("r_c1_mem_req", mem_req_o, 1'b1);
      #3 rst = 1'b0;
      #1 chk1("r_mem_req_cleared", mem_req_o, 1'b0);
      chk1("r_data_ready", data_ready_o, 1'b0);
      data_req_i = 1'b0;
      #1 chk1("r_stall", stallreq_o, 1'b0);
      step();
      #3 rst = 1'b1;
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
      step();
      mem_ack_i = 1'b0;
      #1 chk1("r_late_data_ready", data_ready_o, 1'b0);
      chk1("r_late_inst_ready", inst_ready_o, 1'b0);
      chk1("r_late_mem_req", mem_req_o, 1'b0);
      step();
      chk1("r_late2_data_ready", data_ready_o, 1'b0);
      chk1("r_late2_err", bus_err_o, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
